// File: rtl/pad_bank_ctrl.sv
// -----------------------------------------------------------------------------
// pad_bank_ctrl
//   Controller for a bank of NPADS bidirectional pads. Registers the core's
//   A/OE onto the pads, synchronises pad Y back into the core clock domain, and
//   holds per-pad drive strength / slew / input-enable settings. A pad is
//   reconfigured through a glitch-safe sequence: its OE is forced low for
//   GUARD_CYCLES, the new settings are written, then OE stays low for another
//   GUARD_CYCLES before it is released.
//
// Ports
//   clk, rst                 core clock, synchronous active-high reset
//   cfg_valid/cfg_ready      reconfiguration request handshake
//   cfg_idx/ds/sr/ie         target pad and its new {DS1,DS0}, SR, IE
//   cfg_err                  one-cycle pulse for an out-of-range cfg_idx
//   busy                     a reconfiguration sequence is in progress
//   core_a, core_oe          output data / enable from core
//   core_y                   synchronised pad input to core
//   pad_a/oe/ds0/ds1/sr/ie   to the pad wrappers
//   pad_y                    from the pad wrappers
//
// state    | meaning
// ---------+------------------------------------------------------------
// IDLE     | ready for a request, no pad masked
// QUIESCE  | target pad OE forced low, waiting GUARD_CYCLES
// APPLY    | new settings written into the target pad's config (1 cycle)
// SETTLE   | target pad OE still forced low for GUARD_CYCLES
// -----------------------------------------------------------------------------
module pad_bank_ctrl #(
  parameter int         NPADS        = 8,
  parameter int         GUARD_CYCLES = 4,
  parameter int         SYNC_STAGES  = 2,
  parameter logic [1:0] RST_DS       = 2'b01,
  parameter logic       RST_SR       = 1'b0,
  parameter logic       RST_IE       = 1'b1,
  parameter int         IDXW         = (NPADS > 1) ? $clog2(NPADS) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cfg_valid,
  output logic             cfg_ready,
  input  logic [IDXW-1:0]  cfg_idx,
  input  logic [1:0]       cfg_ds,
  input  logic             cfg_sr,
  input  logic             cfg_ie,
  output logic             cfg_err,
  output logic             busy,
  input  logic [NPADS-1:0] core_a,
  input  logic [NPADS-1:0] core_oe,
  output logic [NPADS-1:0] core_y,
  output logic [NPADS-1:0] pad_a,
  output logic [NPADS-1:0] pad_oe,
  output logic [NPADS-1:0] pad_ds0,
  output logic [NPADS-1:0] pad_ds1,
  output logic [NPADS-1:0] pad_sr,
  output logic [NPADS-1:0] pad_ie,
  input  logic [NPADS-1:0] pad_y
);

  localparam int CNTW = (GUARD_CYCLES > 1) ? $clog2(GUARD_CYCLES) : 1;
  localparam logic [CNTW-1:0] CNT_LOAD = CNTW'(GUARD_CYCLES - 1);
  localparam logic [IDXW:0]   NPADS_V  = NPADS[IDXW:0];

  typedef enum logic [1:0] {S_IDLE, S_QUIESCE, S_APPLY, S_SETTLE} state_t;

  state_t            state_q, state_d;
  logic [CNTW-1:0]   cnt_q, cnt_d;
  logic [IDXW-1:0]   idx_q, idx_d;
  logic [1:0]        cap_ds_q, cap_ds_d;
  logic              cap_sr_q, cap_sr_d;
  logic              cap_ie_q, cap_ie_d;
  logic [NPADS-1:0]  mask_q, mask_d;
  logic [NPADS-1:0]  a_q, a_d;
  logic [NPADS-1:0]  oe_q, oe_d;
  logic [NPADS-1:0]  ds0_q, ds0_d;
  logic [NPADS-1:0]  ds1_q, ds1_d;
  logic [NPADS-1:0]  sr_q, sr_d;
  logic [NPADS-1:0]  ie_q, ie_d;
  logic              cfg_err_q, cfg_err_d;
  logic              busy_q, busy_d;
  logic [NPADS-1:0]  sync_q [SYNC_STAGES];
  logic [NPADS-1:0]  sync_d [SYNC_STAGES];
  logic              req_in_range;

  assign req_in_range = ({1'b0, cfg_idx} < NPADS_V);

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    idx_d     = idx_q;
    cap_ds_d  = cap_ds_q;
    cap_sr_d  = cap_sr_q;
    cap_ie_d  = cap_ie_q;
    mask_d    = mask_q;
    ds0_d     = ds0_q;
    ds1_d     = ds1_q;
    sr_d      = sr_q;
    ie_d      = ie_q;
    cfg_err_d = 1'b0;
    a_d       = core_a;
    oe_d      = core_oe;

    // Stage 0 samples with the IE currently on the pad, so a disabled pad reads 0.
    sync_d[0] = pad_y & ie_q;
    for (int i = 1; i < SYNC_STAGES; i++) begin
      sync_d[i] = sync_q[i-1];
    end

    case (state_q)
      S_IDLE: begin
        if (cfg_valid) begin
          if (req_in_range) begin
            idx_d    = cfg_idx;
            cap_ds_d = cfg_ds;
            cap_sr_d = cfg_sr;
            cap_ie_d = cfg_ie;
            for (int i = 0; i < NPADS; i++) begin
              mask_d[i] = (cfg_idx == IDXW'(i));
            end
            cnt_d   = CNT_LOAD;
            state_d = S_QUIESCE;
          end else begin
            cfg_err_d = 1'b1;
          end
        end
      end
      S_QUIESCE: begin
        if (cnt_q == '0) state_d = S_APPLY;
        else             cnt_d   = cnt_q - CNTW'(1);
      end
      S_APPLY: begin
        for (int i = 0; i < NPADS; i++) begin
          if (idx_q == IDXW'(i)) begin
            ds0_d[i] = cap_ds_q[0];
            ds1_d[i] = cap_ds_q[1];
            sr_d[i]  = cap_sr_q;
            ie_d[i]  = cap_ie_q;
          end
        end
        cnt_d   = CNT_LOAD;
        state_d = S_SETTLE;
      end
      S_SETTLE: begin
        if (cnt_q == '0) begin
          state_d = S_IDLE;
          mask_d  = '0;
        end else begin
          cnt_d = cnt_q - CNTW'(1);
        end
      end
      default: begin
        state_d = S_IDLE;
        mask_d  = '0;
      end
    endcase

    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      idx_q     <= '0;
      cap_ds_q  <= '0;
      cap_sr_q  <= 1'b0;
      cap_ie_q  <= 1'b0;
      mask_q    <= '0;
      a_q       <= '0;
      oe_q      <= '0;
      ds0_q     <= {NPADS{RST_DS[0]}};
      ds1_q     <= {NPADS{RST_DS[1]}};
      sr_q      <= {NPADS{RST_SR}};
      ie_q      <= {NPADS{RST_IE}};
      cfg_err_q <= 1'b0;
      busy_q    <= 1'b0;
      for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      idx_q     <= idx_d;
      cap_ds_q  <= cap_ds_d;
      cap_sr_q  <= cap_sr_d;
      cap_ie_q  <= cap_ie_d;
      mask_q    <= mask_d;
      a_q       <= a_d;
      oe_q      <= oe_d;
      ds0_q     <= ds0_d;
      ds1_q     <= ds1_d;
      sr_q      <= sr_d;
      ie_q      <= ie_d;
      cfg_err_q <= cfg_err_d;
      busy_q    <= busy_d;
      for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= sync_d[i];
    end
  end

  // Ready drops while rst is held so nothing can be accepted during reset,
  // and rises in the very first cycle after release.
  assign cfg_ready = (state_q == S_IDLE) & ~rst;
  assign cfg_err   = cfg_err_q;
  assign busy      = busy_q;
  assign pad_a     = a_q;
  assign pad_oe    = oe_q & ~mask_q;
  assign pad_ds0   = ds0_q;
  assign pad_ds1   = ds1_q;
  assign pad_sr    = sr_q;
  assign pad_ie    = ie_q;
  assign core_y    = sync_q[SYNC_STAGES-1];

endmodule

// File: tb/tb_pad_bank_ctrl.sv
module tb_pad_bank_ctrl;
  localparam int N = 8;
  localparam int G = 4;
  localparam int S = 2;
  localparam int N6 = 6;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // main instance (8 pads)
  logic         cfg_valid = 1'b0;
  logic [2:0]   cfg_idx = '0;
  logic [1:0]   cfg_ds = '0;
  logic         cfg_sr = 1'b0, cfg_ie = 1'b0;
  logic [N-1:0] core_a = '0, core_oe = '0, pad_y = '0;
  logic         cfg_ready, cfg_err, busy;
  logic [N-1:0] core_y, pad_a, pad_oe, pad_ds0, pad_ds1, pad_sr, pad_ie;

  // 6-pad instance, used where an index can actually be out of range
  logic          v6 = 1'b0;
  logic [2:0]    idx6 = '0;
  logic          ready6, err6, busy6;
  logic [N6-1:0] core_y6, pad_a6, pad_oe6, pad_ds0_6, pad_ds1_6, pad_sr6, pad_ie6;

  pad_bank_ctrl #(.NPADS(N), .GUARD_CYCLES(G), .SYNC_STAGES(S)) dut (
    .clk(clk), .rst(rst), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .cfg_idx(cfg_idx), .cfg_ds(cfg_ds), .cfg_sr(cfg_sr), .cfg_ie(cfg_ie),
    .cfg_err(cfg_err), .busy(busy), .core_a(core_a), .core_oe(core_oe),
    .core_y(core_y), .pad_a(pad_a), .pad_oe(pad_oe), .pad_ds0(pad_ds0),
    .pad_ds1(pad_ds1), .pad_sr(pad_sr), .pad_ie(pad_ie), .pad_y(pad_y)
  );

  pad_bank_ctrl #(.NPADS(N6), .GUARD_CYCLES(G), .SYNC_STAGES(S)) dut6 (
    .clk(clk), .rst(rst), .cfg_valid(v6), .cfg_ready(ready6),
    .cfg_idx(idx6), .cfg_ds(2'b11), .cfg_sr(1'b1), .cfg_ie(1'b0),
    .cfg_err(err6), .busy(busy6), .core_a(6'h00), .core_oe(6'h3F),
    .core_y(core_y6), .pad_a(pad_a6), .pad_oe(pad_oe6), .pad_ds0(pad_ds0_6),
    .pad_ds1(pad_ds1_6), .pad_sr(pad_sr6), .pad_ie(pad_ie6), .pad_y(6'h3F)
  );

  int n_vec = 0;
  int n_bad = 0;
  logic chk_en = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Abstract view: a request occupies 2G+1 busy cycles; the new settings are
  // visible once only G busy cycles remain; the target pad is masked while busy.
  logic [N-1:0] m_a, m_oe, m_ds0, m_ds1, m_sr, m_ie;
  logic [N-1:0] m_ys [S];
  int           busy_left;
  int           m_idx;
  logic [1:0]   c_ds;
  logic         c_sr, c_ie;

  task automatic model_step();
    if (rst) begin
      m_a = '0; m_oe = '0;
      m_ds0 = '1; m_ds1 = '0; m_sr = '0; m_ie = '1;
      for (int i = 0; i < S; i++) m_ys[i] = '0;
      busy_left = 0; m_idx = 0;
    end else begin
      for (int i = S-1; i > 0; i--) m_ys[i] = m_ys[i-1];
      m_ys[0] = pad_y & m_ie;
      m_a  = core_a;
      m_oe = core_oe;
      if (busy_left > 0) begin
        busy_left--;
        if (busy_left == G) begin
          m_ds0[m_idx] = c_ds[0];
          m_ds1[m_idx] = c_ds[1];
          m_sr[m_idx]  = c_sr;
          m_ie[m_idx]  = c_ie;
        end
      end else if (cfg_valid && int'(cfg_idx) < N) begin
        busy_left = 2*G + 1;
        m_idx = int'(cfg_idx);
        c_ds = cfg_ds; c_sr = cfg_sr; c_ie = cfg_ie;
      end
    end
  endtask

  task automatic model_check();
    logic [N-1:0] msk;
    msk = (busy_left > 0) ? (N'(1) << m_idx) : '0;
    chk("m_pad_a",  pad_a,  m_a);
    chk("m_pad_oe", pad_oe, m_oe & ~msk);
    chk("m_core_y", core_y, m_ys[S-1]);
    chk("m_ds0",    pad_ds0, m_ds0);
    chk("m_ds1",    pad_ds1, m_ds1);
    chk("m_sr",     pad_sr,  m_sr);
    chk("m_ie",     pad_ie,  m_ie);
    chk("m_busy",   busy,    busy_left > 0);
    chk("m_ready",  cfg_ready, !rst && busy_left == 0);
    chk("m_err",    cfg_err, 1'b0);
  endtask

  initial begin
    forever begin
      @(posedge clk);
      model_step();
      #1;
      if (chk_en) model_check();
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, n_bad=%0d", n_bad);
    $fatal(1, "watchdog");
  end

  // ---------------- directed vectors ----------------
  typedef struct {
    logic [7:0] a, oe, y;
    logic [7:0] exp_a, exp_oe, exp_y;
  } vec_t;
  vec_t tbl [4];

  initial begin
    tbl[0] = '{8'hA5, 8'hFF, 8'h3C, 8'hA5, 8'hFF, 8'h3C};
    tbl[1] = '{8'h5A, 8'h0F, 8'hC3, 8'h5A, 8'h0F, 8'hC3};
    tbl[2] = '{8'h00, 8'h00, 8'hFF, 8'h00, 8'h00, 8'hFF};
    tbl[3] = '{8'hFF, 8'h81, 8'h00, 8'hFF, 8'h81, 8'h00};

    // Reset: 3 cycles
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_ready_low", cfg_ready, 1'b0);
    chk("rst_ds0", pad_ds0, 8'hFF);
    chk("rst_ds1", pad_ds1, 8'h00);
    chk("rst_sr",  pad_sr,  8'h00);
    chk("rst_ie",  pad_ie,  8'hFF);
    chk("rst_oe",  pad_oe,  8'h00);
    chk("rst_busy", busy, 1'b0);
    chk("rst_err6", err6, 1'b0);
    chk_en = 1'b1;
    rst = 1'b0;
    @(negedge clk);
    chk("rel_ready", cfg_ready, 1'b1);

    // Passthrough table
    for (int i = 0; i < 4; i++) begin
      core_a = tbl[i].a; core_oe = tbl[i].oe; pad_y = tbl[i].y;
      @(negedge clk);
      chk("pt_pad_a",  pad_a,  tbl[i].exp_a);
      chk("pt_pad_oe", pad_oe, tbl[i].exp_oe);
      @(negedge clk);
      chk("pt_core_y", core_y, tbl[i].exp_y);
    end

    // Reconfigure pad 3
    core_oe = 8'hFF; core_a = 8'h00; pad_y = 8'hFF;
    cfg_valid = 1'b1; cfg_idx = 3'd3; cfg_ds = 2'b11; cfg_sr = 1'b1; cfg_ie = 1'b0;
    for (int k = 1; k <= 2*G+1; k++) begin
      @(negedge clk);
      cfg_valid = 1'b0;
      chk("rc_oe",   pad_oe, 8'hF7);
      chk("rc_busy", busy, 1'b1);
      chk("rc_ds1_3", pad_ds1[3], (k >= G+2));
      chk("rc_ie_3",  pad_ie[3],  (k < G+2));
    end
    @(negedge clk);
    chk("rc_oe_back", pad_oe, 8'hFF);
    chk("rc_busy_done", busy, 1'b0);
    chk("rc_ready", cfg_ready, 1'b1);
    repeat (S) @(negedge clk);
    chk("rc_core_y", core_y, 8'hF7);
    chk("rc_ds1", pad_ds1, 8'h08);
    chk("rc_sr",  pad_sr,  8'h08);
    chk("rc_ie",  pad_ie,  8'hF7);

    // Back-to-back with cfg_valid held
    cfg_valid = 1'b1; cfg_idx = 3'd1; cfg_ds = 2'b00; cfg_sr = 1'b0; cfg_ie = 1'b1;
    @(negedge clk);
    cfg_idx = 3'd2; cfg_ds = 2'b10;
    chk("b2b_first_oe", pad_oe, 8'hFD);
    for (int k = 2; k <= 2*G+1; k++) begin
      @(negedge clk);
      chk("b2b_one_mask", ($countones(~pad_oe) <= 1), 1'b1);
    end
    @(negedge clk);
    chk("b2b_idle_busy",  busy, 1'b0);
    chk("b2b_idle_ready", cfg_ready, 1'b1);
    chk("b2b_idle_oe",    pad_oe, 8'hFF);
    @(negedge clk);
    cfg_valid = 1'b0;
    chk("b2b_second_busy", busy, 1'b1);
    chk("b2b_second_oe",   pad_oe, 8'hFB);
    for (int k = 2; k <= 2*G+1; k++) begin
      @(negedge clk);
      chk("b2b_one_mask", ($countones(~pad_oe) <= 1), 1'b1);
    end
    @(negedge clk);
    chk("b2b_done", busy, 1'b0);
    chk("b2b_ds0", pad_ds0, 8'hF9);
    chk("b2b_ds1", pad_ds1, 8'h0C);

    // Reset during SETTLE
    cfg_valid = 1'b1; cfg_idx = 3'd5; cfg_ds = 2'b10; cfg_sr = 1'b1; cfg_ie = 1'b0;
    @(negedge clk);
    cfg_valid = 1'b0;
    repeat (G+2) @(negedge clk);
    chk("rs_applied", pad_ds1[5], 1'b1);
    chk("rs_masked",  pad_oe, 8'hDF);
    rst = 1'b1;
    @(negedge clk);
    chk("rs_busy", busy, 1'b0);
    chk("rs_ds0", pad_ds0, 8'hFF);
    chk("rs_ds1", pad_ds1, 8'h00);
    chk("rs_sr",  pad_sr,  8'h00);
    chk("rs_ie",  pad_ie,  8'hFF);
    rst = 1'b0;
    @(negedge clk);
    chk("rs_oe_free", pad_oe, 8'hFF);
    chk("rs_ready", cfg_ready, 1'b1);

    // Out-of-range on the 6-pad instance
    for (int j = 6; j <= 7; j++) begin
      v6 = 1'b1; idx6 = 3'(j);
      @(negedge clk);
      v6 = 1'b0;
      chk("oor_err",  err6, 1'b1);
      chk("oor_busy", busy6, 1'b0);
      @(negedge clk);
      chk("oor_err_pulse", err6, 1'b0);
      chk("oor_ds1", pad_ds1_6, 6'h00);
      chk("oor_oe",  pad_oe6,   6'h3F);
    end
    v6 = 1'b1; idx6 = 3'd5;
    @(negedge clk);
    v6 = 1'b0;
    chk("inr_err",  err6, 1'b0);
    chk("inr_busy", busy6, 1'b1);
    chk("inr_oe",   pad_oe6, 6'h1F);
    repeat (2*G+1) @(negedge clk);
    chk("inr_done", busy6, 1'b0);
    chk("inr_ds1",  pad_ds1_6, 6'h20);

    // Randomised traffic against the model
    for (int c = 0; c < 600; c++) begin
      @(negedge clk);
      core_a    = N'($urandom);
      core_oe   = N'($urandom);
      pad_y     = N'($urandom);
      cfg_valid = ($urandom_range(0, 3) == 0);
      cfg_idx   = 3'($urandom);
      cfg_ds    = 2'($urandom);
      cfg_sr    = 1'($urandom);
      cfg_ie    = 1'($urandom);
      rst       = ($urandom_range(0, 149) == 0);
    end
    @(negedge clk);
    rst = 1'b0; cfg_valid = 1'b0;
    repeat (3) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
